// File: rtl/poly_notebank_pkg.sv
// Shared codes, state types and the output clip helper for the polyphonic voice bank.
package poly_notebank_pkg;

  localparam logic [1:0] WAVE_SAW = 2'd0;
  localparam logic [1:0] WAVE_SQR = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;
  localparam logic [1:0] WAVE_OFF = 2'd3;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MAC  = 2'd2,
    ST_OUT  = 2'd3
  } frame_state_t;

  // Symmetric clip to +/-(2^(dw-1)-1) so the output never reaches the lone negative code.
  function automatic longint sat_sym(input longint v, input int dw);
    longint mx;
    mx = (longint'(1) <<< (dw - 1)) - 1;
    if (v > mx)
      return mx;
    else if (v < -mx)
      return -mx;
    else
      return v;
  endfunction

endpackage

// File: rtl/poly_notebank_voice_step.sv
// One voice's per-sample update: waveform lookup, phase advance and envelope step.
module poly_voice_step
  import poly_notebank_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int ENV_W   = 18,
  parameter int PHASE_W = 32,
  parameter int RATE_W  = 16
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic [PHASE_W-1:0] inc,
  input  logic [1:0]         env_state,
  input  logic [ENV_W-1:0]   env,
  input  logic [RATE_W-1:0]  attack_rate,
  input  logic [RATE_W-1:0]  release_rate,
  input  logic [ENV_W-1:0]   sustain_level,
  input  logic [1:0]         wave_sel,
  output logic [DATA_W-1:0]  wave,
  output logic [PHASE_W-1:0] phase_next,
  output logic [ENV_W-1:0]   env_next,
  output logic [1:0]         env_state_next
);

  localparam logic [DATA_W-1:0] FULL = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] p;
  logic [DATA_W-2:0] fold;
  logic [ENV_W:0]    env_up;

  assign p          = phase[PHASE_W-1 -: DATA_W];
  assign fold       = p[DATA_W-1] ? ~p[DATA_W-2:0] : p[DATA_W-2:0];
  assign phase_next = phase + inc;
  assign env_up     = {1'b0, env} + (ENV_W+1)'(attack_rate);

  // Triangle folds the upper half back down, then re-centres by flipping the MSB.
  always_comb begin
    wave = '0;
    case (wave_sel)
      WAVE_SAW: wave = {~p[DATA_W-1], p[DATA_W-2:0]};
      WAVE_SQR: wave = p[DATA_W-1] ? -FULL : FULL;
      WAVE_TRI: wave = {~fold[DATA_W-2], fold[DATA_W-3:0], 1'b0};
      default:  wave = '0;
    endcase
  end

  always_comb begin
    env_next       = env;
    env_state_next = env_state;
    case (env_state)
      ENV_ATTACK: begin
        if (env_up >= {1'b0, sustain_level}) begin
          env_next       = sustain_level;
          env_state_next = ENV_SUSTAIN;
        end else begin
          env_next = env_up[ENV_W-1:0];
        end
      end
      ENV_SUSTAIN: env_next = env;
      ENV_RELEASE: begin
        if ({1'b0, env} <= (ENV_W+1)'(release_rate)) begin
          env_next       = '0;
          env_state_next = ENV_IDLE;
        end else begin
          env_next = env - ENV_W'(release_rate);
        end
      end
      default: env_next = '0;
    endcase
  end

endmodule

// File: rtl/poly_notebank.sv
// Time-multiplexed voice bank: one shared step/multiply path walks every voice once per
// sample_tick, accumulates the scaled voices and emits one saturated mono sample.
module poly_notebank
  import poly_notebank_pkg::*;
#(
  parameter int VOICES  = 4,
  parameter int DATA_W  = 24,
  parameter int ENV_W   = 18,
  parameter int PHASE_W = 32,
  parameter int RATE_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       sample_tick,
  input  logic                       note_on,
  input  logic                       note_off,
  input  logic [$clog2(VOICES)-1:0]  voice_sel,
  input  logic [PHASE_W-1:0]         phase_inc,
  input  logic [1:0]                 wave_sel,
  input  logic [RATE_W-1:0]          attack_rate,
  input  logic [RATE_W-1:0]          release_rate,
  input  logic [ENV_W-1:0]           sustain_level,
  output logic                       cmd_ready,
  output logic [DATA_W-1:0]          audio_out,
  output logic                       audio_valid,
  output logic [VOICES-1:0]          active,
  output logic                       busy,
  output logic                       overrun
);

  localparam int VI_W   = $clog2(VOICES);
  localparam int ACC_W  = DATA_W + VI_W;
  localparam int PROD_W = DATA_W + ENV_W + 1;

  frame_state_t state_q, state_d;
  logic [VI_W-1:0] idx_q;

  logic [PHASE_W-1:0] phase_q [VOICES];
  logic [PHASE_W-1:0] inc_q   [VOICES];
  logic [1:0]         wave_q  [VOICES];
  env_state_t         est_q   [VOICES];
  logic [ENV_W-1:0]   env_q   [VOICES];
  logic [ENV_W-1:0]   sus_q   [VOICES];
  logic [RATE_W-1:0]  att_q   [VOICES];
  logic [RATE_W-1:0]  rel_q   [VOICES];

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, prod_acc;

  logic [DATA_W-1:0]  wave_s;
  logic [PHASE_W-1:0] phase_n;
  logic [ENV_W-1:0]   env_n;
  logic [1:0]         est_n;

  poly_voice_step #(
    .DATA_W (DATA_W),
    .ENV_W  (ENV_W),
    .PHASE_W(PHASE_W),
    .RATE_W (RATE_W)
  ) u_step (
    .phase         (phase_q[idx_q]),
    .inc           (inc_q[idx_q]),
    .env_state     (est_q[idx_q]),
    .env           (env_q[idx_q]),
    .attack_rate   (att_q[idx_q]),
    .release_rate  (rel_q[idx_q]),
    .sustain_level (sus_q[idx_q]),
    .wave_sel      (wave_q[idx_q]),
    .wave          (wave_s),
    .phase_next    (phase_n),
    .env_next      (env_n),
    .env_state_next(est_n)
  );

  // Product uses the envelope before this sample's step; the shift back by ENV_W keeps
  // a full-scale envelope at unity gain.
  assign prod_d   = PROD_W'($signed(wave_s)) * PROD_W'($signed({1'b0, env_q[idx_q]}));
  assign prod_acc = ACC_W'(prod_q >>> ENV_W);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    active = '0;
    for (int v = 0; v < VOICES; v++)
      active[v] = (est_q[v] != ENV_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_b)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sample_tick) state_d = ST_RUN;
      ST_RUN:  if (idx_q == VI_W'(VOICES - 1)) state_d = ST_MAC;
      ST_MAC:  state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Commands only land in IDLE, so they never race the RUN write-back to the same voice.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
        wave_q[v]  <= '0;
        est_q[v]   <= ENV_IDLE;
        env_q[v]   <= '0;
        sus_q[v]   <= '0;
        att_q[v]   <= '0;
        rel_q[v]   <= '0;
      end
      idx_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      overrun     <= sample_tick && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (note_on) begin
            phase_q[voice_sel] <= '0;
            inc_q[voice_sel]   <= phase_inc;
            wave_q[voice_sel]  <= wave_sel;
            att_q[voice_sel]   <= attack_rate;
            rel_q[voice_sel]   <= release_rate;
            sus_q[voice_sel]   <= sustain_level;
            est_q[voice_sel]   <= ENV_ATTACK;
          end else if (note_off && ((est_q[voice_sel] == ENV_ATTACK) ||
                                    (est_q[voice_sel] == ENV_SUSTAIN))) begin
            est_q[voice_sel] <= ENV_RELEASE;
          end
          if (sample_tick) begin
            idx_q <= '0;
            acc_q <= '0;
          end
        end
        ST_RUN: begin
          prod_q         <= prod_d;
          phase_q[idx_q] <= phase_n;
          env_q[idx_q]   <= env_n;
          est_q[idx_q]   <= env_state_t'(est_n);
          idx_q          <= idx_q + VI_W'(1);
          if (idx_q != '0)
            acc_q <= acc_q + prod_acc;
        end
        ST_MAC: acc_q <= acc_q + prod_acc;
        ST_OUT: begin
          audio_out   <= DATA_W'(sat_sym(longint'(acc_q), DATA_W));
          audio_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_notebank.sv
// Directed bench for poly_notebank; rate field widened to 17 bits so a 65536 release step fits.
module tb_poly_notebank;

  logic        clk = 1'b0;
  logic        rst_b, sample_tick, note_on, note_off;
  logic [1:0]  voice_sel;
  logic [31:0] phase_inc;
  logic [1:0]  wave_sel;
  logic [16:0] attack_rate, release_rate;
  logic [17:0] sustain_level;
  logic        cmd_ready, audio_valid, busy, overrun;
  logic [23:0] audio_out;
  logic [3:0]  active;

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  poly_notebank #(
    .VOICES (4),
    .DATA_W (24),
    .ENV_W  (18),
    .PHASE_W(32),
    .RATE_W (17)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .sample_tick  (sample_tick),
    .note_on      (note_on),
    .note_off     (note_off),
    .voice_sel    (voice_sel),
    .phase_inc    (phase_inc),
    .wave_sel     (wave_sel),
    .attack_rate  (attack_rate),
    .release_rate (release_rate),
    .sustain_level(sustain_level),
    .cmd_ready    (cmd_ready),
    .audio_out    (audio_out),
    .audio_valid  (audio_valid),
    .active       (active),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic on, input logic off, input logic [1:0] sel,
                               input logic [31:0] inc, input logic [1:0] wv,
                               input logic [16:0] att, input logic [16:0] rel,
                               input logic [17:0] sus);
    note_on       = on;
    note_off      = off;
    voice_sel     = sel;
    phase_inc     = inc;
    wave_sel      = wv;
    attack_rate   = att;
    release_rate  = rel;
    sustain_level = sus;
    step_clk();
    note_on  = 1'b0;
    note_off = 1'b0;
  endtask

  // Tick in the current cycle, then wait (bounded) for audio_valid and check latency and sample.
  task automatic run_frame(input string tag, input logic signed [63:0] exp_out);
    int n;
    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    n = 1;
    while (!audio_valid && n < 20) begin
      step_clk();
      n++;
    end
    checkOutput({tag, "_latency"}, n, 7);
    checkOutput({tag, "_out"}, $signed(audio_out), exp_out);
  endtask

  initial begin
    int n_valid;
    int cyc;
    vectors       = 0;
    miscompares   = 0;
    rst_b         = 1'b1;
    sample_tick   = 1'b0;
    note_on       = 1'b0;
    note_off      = 1'b0;
    voice_sel     = '0;
    phase_inc     = '0;
    wave_sel      = '0;
    attack_rate   = '0;
    release_rate  = '0;
    sustain_level = '0;
    repeat (3) step_clk();
    rst_b = 1'b0;

    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_audio_out", $signed(audio_out), 0);
    checkOutput("rst_audio_valid", audio_valid, 0);
    checkOutput("rst_overrun", overrun, 0);

    run_frame("empty", 0);
    checkOutput("empty_active", active, 0);

    // Square at phase 0, attack 32768/sample to 131072: env 0, 32768, 65536, 98304, 131072.
    applyStimulus(1, 0, 0, 32'd0, 2'd1, 17'd32768, 17'd65536, 18'd131072);
    checkOutput("v0_active", active, 4'b0001);
    run_frame("v0_f1", 0);
    run_frame("v0_f2", 1048575);
    run_frame("v0_f3", 2097151);
    run_frame("v0_f4", 3145727);
    run_frame("v0_f5", 4194303);

    applyStimulus(0, 1, 0, 32'd0, 2'd0, 17'd0, 17'd0, 18'd0);
    run_frame("rel_f1", 4194303);
    checkOutput("rel_active_f1", active, 4'b0001);
    run_frame("rel_f2", 2097151);
    checkOutput("rel_active_f2", active, 4'b0000);
    run_frame("rel_f3", 0);

    for (int v = 0; v < 4; v++)
      applyStimulus(1, 0, v[1:0], 32'd0, 2'd1, 17'd131071, 17'd0, 18'd262143);
    run_frame("sat_f1", 0);
    run_frame("sat_f2", 8388607);
    run_frame("sat_f3", 8388607);
    run_frame("sat_f4", 8388607);
    checkOutput("sat_active", active, 4'b1111);

    // Half-turn increment: phase 0, 0x80000000, then wraps back to 0.
    for (int v = 0; v < 4; v++)
      applyStimulus(1, 0, v[1:0], 32'h8000_0000, 2'd1, 17'd0, 17'd0, 18'd262143);
    run_frame("wrap_f1", 8388607);
    run_frame("wrap_f2", -8388607);
    run_frame("wrap_f3", 8388607);

    sample_tick = 1'b1;
    step_clk();
    sample_tick = 1'b0;
    step_clk();
    checkOutput("midrun_busy_before", busy, 1);
    rst_b = 1'b1;
    step_clk();
    rst_b = 1'b0;
    checkOutput("midrun_busy", busy, 0);
    checkOutput("midrun_cmd_ready", cmd_ready, 1);
    checkOutput("midrun_audio_out", $signed(audio_out), 0);
    checkOutput("midrun_audio_valid", audio_valid, 0);
    checkOutput("midrun_active", active, 0);
    n_valid = 0;
    repeat (8) begin
      if (audio_valid) n_valid++;
      step_clk();
    end
    checkOutput("midrun_no_valid", n_valid, 0);

    applyStimulus(1, 1, 1, 32'd0, 2'd1, 17'd32768, 17'd65535, 18'd131072);
    checkOutput("onoff_active", active, 4'b0010);
    run_frame("onoff_f1", 0);
    run_frame("onoff_f2", 1048575);

    // Tick, then a held note_on for voice 2 and a second tick while the frame runs.
    sample_tick = 1'b1;
    step_clk();
    checkOutput("busy_cmd_ready", cmd_ready, 0);
    note_on       = 1'b1;
    voice_sel     = 2'd2;
    phase_inc     = 32'd0;
    wave_sel      = 2'd1;
    attack_rate   = 17'd65536;
    release_rate  = 17'd0;
    sustain_level = 18'd65536;
    step_clk();
    sample_tick = 1'b0;
    checkOutput("overrun_pulse", overrun, 1);
    checkOutput("busy_active", active, 4'b0010);
    step_clk();
    checkOutput("overrun_clear", overrun, 0);
    cyc     = 3;
    n_valid = 0;
    while (!cmd_ready && cyc < 20) begin
      if (audio_valid) n_valid++;
      step_clk();
      cyc++;
    end
    checkOutput("held_cmd_cycle", cyc, 7);
    checkOutput("busy_frame_out", $signed(audio_out), 2097151);
    if (audio_valid) n_valid++;
    step_clk();
    note_on = 1'b0;
    checkOutput("held_cmd_active", active, 4'b0110);
    repeat (4) begin
      if (audio_valid) n_valid++;
      step_clk();
    end
    checkOutput("single_valid", n_valid, 1);

    run_frame("mix_f4", 3145727);
    run_frame("mix_f5", 6291454);
    applyStimulus(0, 1, 1, 32'd0, 2'd0, 17'd0, 17'd0, 18'd0);
    run_frame("mix_f6", 6291454);

    // Voice 1 now in release at 65537; retrigger with zero attack must hold that level.
    applyStimulus(1, 0, 1, 32'd0, 2'd1, 17'd0, 17'd0, 18'd131072);
    run_frame("retrig_f7", 4194334);
    checkOutput("retrig_active", active, 4'b0110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
